// File: rtl/fetch_seq.sv
// Instruction-fetch / program-counter sequencer: FETCH -> EXEC -> next PC, with HLT stop.
// Optional macro FETCH_SEQ_HALT_RESUME_EN adds a resume input that leaves HALT at pc+1.
module fetch_seq #(
    parameter logic [11:0] RESET_PC = 12'h000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
`ifdef FETCH_SEQ_HALT_RESUME_EN
    input  logic             resume,
`endif
    output logic             imem_req,
    output logic [11:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [15:0]      imem_rdata,
    output logic [11:0]      pc,
    output logic [15:0]      instr,
    output logic             instr_valid,
    input  logic             ex_done,
    input  logic             jflag,
    input  logic [11:0]      jdest,
    output logic             halted,
    output logic [CNT_W-1:0] retired,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t           r_state;
    logic [11:0]      r_fetch_pc;
    logic [11:0]      r_pc;
    logic [15:0]      r_instr;
    logic             r_instr_valid;
    logic             r_halted;
    logic [CNT_W-1:0] r_retired;

    logic             w_is_hlt;
    logic             w_resume;

    assign w_is_hlt = (r_instr[15:14] == 2'b11) && (r_instr[7:4] == 4'b1111);

`ifdef FETCH_SEQ_HALT_RESUME_EN
    assign w_resume = resume;
`else
    assign w_resume = 1'b0;
`endif

    // jflag/jdest are only looked at inside the EXEC ex_done branch, so
    // garbage on them during FETCH or HALT cannot disturb any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_FETCH;
            r_fetch_pc    <= RESET_PC;
            r_pc          <= RESET_PC;
            r_instr       <= 16'h0000;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
            r_retired     <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_ack) begin
                        r_instr       <= imem_rdata;
                        r_pc          <= r_fetch_pc;
                        r_instr_valid <= 1'b1;
                        r_state       <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (ex_done) begin
                        r_retired     <= r_retired + CNT_W'(1);
                        r_instr_valid <= 1'b0;
                        if (w_is_hlt) begin
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end else if (jflag) begin
                            r_fetch_pc <= jdest;
                            r_state    <= S_FETCH;
                        end else begin
                            r_fetch_pc <= r_pc + 12'd1;
                            r_state    <= S_FETCH;
                        end
                    end
                end
                S_HALT: begin
                    if (w_resume) begin
                        r_fetch_pc <= r_pc + 12'd1;
                        r_halted   <= 1'b0;
                        r_state    <= S_FETCH;
                    end
                end
                default: begin
                    r_state       <= S_FETCH;
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = (r_state == S_FETCH);
    assign imem_addr   = r_fetch_pc;
    assign pc          = r_pc;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign halted      = r_halted;
    assign retired     = r_retired;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: vector table for the fetch/jump/halt flow plus
// hand-written sequences for halt hold, reset during EXEC and a slow memory ack.
module tb_fetch_seq;

    logic        clk;
    logic        rst;
    logic        resume;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [11:0] pc;
    logic [15:0] instr;
    logic        instr_valid;
    logic        ex_done;
    logic        jflag;
    logic [11:0] jdest;
    logic        halted;
    logic [15:0] retired;
    logic [1:0]  dbg_state;

    int n_checks;
    int n_miscompares;

    fetch_seq #(.RESET_PC(12'h000), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef FETCH_SEQ_HALT_RESUME_EN
        .resume      (resume),
`endif
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .pc          (pc),
        .instr       (instr),
        .instr_valid (instr_valid),
        .ex_done     (ex_done),
        .jflag       (jflag),
        .jdest       (jdest),
        .halted      (halted),
        .retired     (retired),
        .dbg_state   (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ack;
        logic [15:0] rdata;
        logic        exd;
        logic        jf;
        logic [11:0] jd;
        logic        req;
        logic [11:0] addr;
        logic        iv;
        logic [11:0] pc;
        logic [15:0] instr;
        logic        halt;
        logic [15:0] ret;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(logic r, logic a, logic [15:0] rd, logic e, logic f,
                                logic [11:0] d, logic q, logic [11:0] ad, logic v,
                                logic [11:0] p, logic [15:0] i, logic h, logic [15:0] rt);
        vec_t t;
        t.rst = r; t.ack = a; t.rdata = rd; t.exd = e; t.jf = f; t.jd = d;
        t.req = q; t.addr = ad; t.iv = v; t.pc = p; t.instr = i; t.halt = h; t.ret = rt;
        return t;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
    task automatic step(input logic r, input logic a, input logic [15:0] rd,
                        input logic e, input logic f, input logic [11:0] d);
        @(negedge clk);
        rst = r; imem_ack = a; imem_rdata = rd; ex_done = e; jflag = f; jdest = d;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic q, input logic [11:0] ad,
                              input logic v, input logic [11:0] p, input logic [15:0] i,
                              input logic h, input logic [15:0] rt);
        cmp({tag, ".imem_req"}, 32'(imem_req), 32'(q));
        cmp({tag, ".imem_addr"}, 32'(imem_addr), 32'(ad));
        cmp({tag, ".instr_valid"}, 32'(instr_valid), 32'(v));
        cmp({tag, ".pc"}, 32'(pc), 32'(p));
        cmp({tag, ".instr"}, 32'(instr), 32'(i));
        cmp({tag, ".halted"}, 32'(halted), 32'(h));
        cmp({tag, ".retired"}, 32'(retired), 32'(rt));
    endtask

    initial begin
        n_checks = 0;
        n_miscompares = 0;
        rst = 1'b1; resume = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0;
        ex_done = 1'b0; jflag = 1'b0; jdest = 12'h0;

        //               rst ack rdata    exd jf jdest    | req addr    iv pc       instr    h  ret
        vecs[0]  = mk(1, 0, 16'h0000, 0, 0, 12'h000,  1, 12'h000, 0, 12'h000, 16'h0000, 0, 16'd0);
        vecs[1]  = mk(0, 1, 16'h0000, 0, 0, 12'h000,  0, 12'h000, 1, 12'h000, 16'h0000, 0, 16'd0);
        vecs[2]  = mk(0, 0, 16'h0000, 1, 0, 12'h000,  1, 12'h001, 0, 12'h000, 16'h0000, 0, 16'd1);
        vecs[3]  = mk(0, 1, 16'h0001, 0, 0, 12'h000,  0, 12'h001, 1, 12'h001, 16'h0001, 0, 16'd1);
        vecs[4]  = mk(0, 0, 16'h0000, 1, 0, 12'h000,  1, 12'h002, 0, 12'h001, 16'h0001, 0, 16'd2);
        vecs[5]  = mk(0, 1, 16'h0002, 0, 0, 12'h000,  0, 12'h002, 1, 12'h002, 16'h0002, 0, 16'd2);
        vecs[6]  = mk(0, 0, 16'h0000, 1, 1, 12'h010,  1, 12'h010, 0, 12'h002, 16'h0002, 0, 16'd3);
        vecs[7]  = mk(0, 1, 16'h1234, 0, 0, 12'h000,  0, 12'h010, 1, 12'h010, 16'h1234, 0, 16'd3);
        vecs[8]  = mk(0, 0, 16'h0000, 1, 1, 12'h0F4,  1, 12'h0F4, 0, 12'h010, 16'h1234, 0, 16'd4);
        vecs[9]  = mk(0, 1, 16'h5678, 0, 0, 12'h000,  0, 12'h0F4, 1, 12'h0F4, 16'h5678, 0, 16'd4);
        vecs[10] = mk(0, 0, 16'h0000, 1, 1, 12'h010,  1, 12'h010, 0, 12'h0F4, 16'h5678, 0, 16'd5);
        vecs[11] = mk(0, 1, 16'h1234, 0, 0, 12'h000,  0, 12'h010, 1, 12'h010, 16'h1234, 0, 16'd5);
        vecs[12] = mk(0, 0, 16'h0000, 1, 0, 12'h0F4,  1, 12'h011, 0, 12'h010, 16'h1234, 0, 16'd6);
        vecs[13] = mk(0, 1, 16'h4321, 1, 1, 12'hABC,  0, 12'h011, 1, 12'h011, 16'h4321, 0, 16'd6);
        vecs[14] = mk(0, 1, 16'hFFFF, 0, 1, 12'h777,  0, 12'h011, 1, 12'h011, 16'h4321, 0, 16'd6);
        vecs[15] = mk(0, 0, 16'h0000, 1, 1, 12'hFFF,  1, 12'hFFF, 0, 12'h011, 16'h4321, 0, 16'd7);
        vecs[16] = mk(0, 1, 16'h0ABC, 0, 0, 12'h000,  0, 12'hFFF, 1, 12'hFFF, 16'h0ABC, 0, 16'd7);
        vecs[17] = mk(0, 0, 16'h0000, 1, 0, 12'h123,  1, 12'h000, 0, 12'hFFF, 16'h0ABC, 0, 16'd8);
        vecs[18] = mk(0, 1, 16'h0000, 0, 0, 12'h000,  0, 12'h000, 1, 12'h000, 16'h0000, 0, 16'd8);
        vecs[19] = mk(0, 0, 16'h0000, 1, 1, 12'h020,  1, 12'h020, 0, 12'h000, 16'h0000, 0, 16'd9);
        vecs[20] = mk(0, 1, 16'hC0F0, 0, 0, 12'h000,  0, 12'h020, 1, 12'h020, 16'hC0F0, 0, 16'd9);
        vecs[21] = mk(0, 0, 16'h0000, 1, 1, 12'h0F4,  0, 12'h020, 0, 12'h020, 16'hC0F0, 1, 16'd10);
        vecs[22] = mk(0, 1, 16'h1111, 1, 1, 12'h0F4,  0, 12'h020, 0, 12'h020, 16'hC0F0, 1, 16'd10);

        for (int k = 0; k < 23; k++) begin
            step(vecs[k].rst, vecs[k].ack, vecs[k].rdata, vecs[k].exd, vecs[k].jf, vecs[k].jd);
            expect_out($sformatf("vec%0d", k), vecs[k].req, vecs[k].addr, vecs[k].iv,
                       vecs[k].pc, vecs[k].instr, vecs[k].halt, vecs[k].ret);
        end

        // HALT holds for 20+ cycles regardless of ack/ex_done/jflag noise.
        for (int k = 0; k < 22; k++) begin
            step(0, 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 12'($urandom));
            expect_out($sformatf("halt_hold%0d", k), 0, 12'h020, 0, 12'h020, 16'hC0F0, 1, 16'd10);
        end

`ifdef FETCH_SEQ_HALT_RESUME_EN
        resume = 1'b1;
        step(0, 0, 16'h0, 0, 0, 12'h0);
        resume = 1'b0;
        expect_out("resume", 1, 12'h021, 0, 12'h020, 16'hC0F0, 0, 16'd10);
`endif

        // Reset, retire 7 NOPs, then reset mid-EXEC of the 8th.
        step(1, 0, 16'h0, 0, 0, 12'h0);
        expect_out("rst2", 1, 12'h000, 0, 12'h000, 16'h0000, 0, 16'd0);
        for (int k = 0; k < 7; k++) begin
            step(0, 1, 16'h0100, 0, 0, 12'h0);
            step(0, 0, 16'h0, 1, 0, 12'h0);
        end
        expect_out("seven_done", 1, 12'h007, 0, 12'h006, 16'h0100, 0, 16'd7);
        step(0, 1, 16'h0200, 0, 0, 12'h0);
        expect_out("exec8", 0, 12'h007, 1, 12'h007, 16'h0200, 0, 16'd7);
        step(1, 0, 16'h0, 1, 1, 12'h0F4);
        expect_out("rst_mid_exec", 1, 12'h000, 0, 12'h000, 16'h0000, 0, 16'd0);
        cmp("rst_mid_exec.state", 32'(dbg_state), 32'd0);

        // Slow memory: fetch at 005 waits three cycles for ack, jflag toggling.
        step(0, 1, 16'h0000, 0, 0, 12'h0);
        step(0, 0, 16'h0, 1, 1, 12'h005);
        expect_out("jump005", 1, 12'h005, 0, 12'h000, 16'h0000, 0, 16'd1);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 16'hDEAD, 1'(k % 2), 1'(~k[0]), 12'h3A0);
            expect_out($sformatf("wait%0d", k), 1, 12'h005, 0, 12'h000, 16'h0000, 0, 16'd1);
        end
        step(0, 1, 16'h1111, 0, 1, 12'h3A0);
        expect_out("late_ack", 0, 12'h005, 1, 12'h005, 16'h1111, 0, 16'd1);
        step(0, 0, 16'h0, 1, 0, 12'h3A0);
        expect_out("after_slow", 1, 12'h006, 0, 12'h005, 16'h1111, 0, 16'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- Instruction-fetch and program-counter sequencer for the 16-bit core with a 12-bit PC.
- Fetches one instruction at a time from instruction memory and presents it with its PC to decode and jump calculation.
- Consumes the jump calculator's jflag/jdest result at the end of each instruction to select the next fetch address.
- Non-pipelined multicycle: fetch, then execute-wait, then redirect.

Parameters:
- RESET_PC, 12'h000, first fetch address after reset.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request, high only in FETCH.
- imem_addr  output  12  fetch address, equals internal fetch_pc.
- imem_ack  input  1  memory returns imem_rdata this cycle; sampled only while imem_req=1.
- imem_rdata  input  16  instruction word.
- pc  output  12  PC of the instruction held in instr; drives jump calculation.
- instr  output  16  current instruction register.
- instr_valid  output  1  instr/pc are valid and executing.
- ex_done  input  1  datapath has finished the current instruction; sampled only while instr_valid=1.
- jflag  input  1  branch taken, from jump calculator; sampled only with ex_done.
- jdest  input  12  branch target, from jump calculator; sampled only with ex_done.
- halted  output  1  core stopped on HLT.
- retired  output  CNT_W  count of completed instructions.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- States: FETCH, EXEC, HALT. Encoding is free.
- Reset values (on any rising edge with rst=1, including mid-fetch or mid-execute):
  - state=FETCH, fetch_pc=RESET_PC, pc=RESET_PC.
  - instr=16'h0000, instr_valid=0, halted=0, retired=0.
  - imem_req follows state, so it is 1 in the first cycle after reset.
- FETCH:
  - imem_req=1, imem_addr=fetch_pc.
  - On imem_ack=1: instr<=imem_rdata, pc<=fetch_pc, instr_valid<=1, go to EXEC.
  - Zero-wait memory (ack in the same cycle as req) gives instr_valid in the next cycle.
  - imem_req stays high and fetch_pc stays stable until ack.
- EXEC:
  - imem_req=0. instr, pc and instr_valid are held stable until ex_done.
  - On ex_done=1, retired<=retired+1 (wraps modulo 2^CNT_W), then:
    - If instr is HLT (instr[15:14]=2'b11 and instr[7:4]=4'b1111): instr_valid<=0, halted<=1, go to HALT.
    - Else if jflag=1: fetch_pc<=jdest, instr_valid<=0, go to FETCH.
    - Else: fetch_pc<=pc+1 (12-bit, 12'hFFF wraps to 12'h000), instr_valid<=0, go to FETCH.
- jflag/jdest are ignored except in the ex_done cycle of EXEC. X or garbage on them at other times must not affect state.
- HALT:
  - imem_req=0, instr_valid=0, halted=1.
  - pc keeps the HLT address, retired is frozen.
  - Only rst leaves HALT unless HALT_RESUME_EN is defined.
- imem_ack while imem_req=0 is ignored. ex_done while instr_valid=0 is ignored.
- Minimum cycle count per instruction is 2 (1 FETCH + 1 EXEC).

Optional Feature:
- Macro: FETCH_SEQ_HALT_RESUME_EN.
- Defined:
  - Adds input port resume (1 bit).
  - resume=1 in HALT sets fetch_pc<=pc+1 (wrapping), halted<=0, and goes to FETCH on the next edge.
  - resume is ignored in FETCH and EXEC; rst has priority over resume.
- Not defined: no resume port; HALT is terminal until rst.

Test Plan:
- Reset with RESET_PC=12'h000, memory at 0/1/2 = 16'h0000/16'h0001/16'h0002, zero-wait ack, ex_done one cycle after instr_valid -> imem_addr sequence 000,001,002; pc/instr pairs match; retired=3 after the third ex_done.
- Memory ack delayed 3 cycles -> imem_req and imem_addr=12'h005 stay stable for 3 cycles; instr_valid rises the cycle after ack; jflag toggling during FETCH causes no redirect.
- Instruction at 12'h010 with ex_done and jflag=1, jdest=12'h0F4 -> next imem_addr=12'h0F4. Same case with jflag=0 -> next imem_addr=12'h011.
- pc=12'hFFF, not-taken instruction -> next fetch address 12'h000, no X.
- HLT (16'hC0F0) at 12'h020 -> halted=1, instr_valid=0, imem_req=0 for 20+ cycles, retired frozen, pc=12'h020. With FETCH_SEQ_HALT_RESUME_EN, a resume pulse -> next imem_addr=12'h021, halted=0.
- rst asserted for one cycle during EXEC with retired=7 -> next cycle state FETCH, imem_addr=RESET_PC, retired=0, instr_valid=0, halted=0.
